div_iter_unit: RTL and testbench
================================

# div_iter_unit

Parametrised iterative radix-2 non-restoring divider for the multi-cycle datapath's multiply/divide unit. Takes a signed or unsigned WIDTH-bit dividend and divisor on a start pulse and returns quotient and remainder after a fixed latency. Adds four things to the previous divider generation: registered results, a one-cycle done pulse, an abort input for exception flush, and optional divide-by-zero detection.

## Interface
- WIDTH, 32, operand/result width in bits (≥4); iteration counter width is derived as $clog2(WIDTH)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- signed_div  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- abort  in  1  cancel in-flight operation; priority over start
- dividend  in  WIDTH  sampled with start
- divisor  in  WIDTH  sampled with start
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse; q/r valid from this cycle on
- q  out  WIDTH  quotient, registered, held until next FIX
- r  out  WIDTH  remainder, registered, held until next FIX
- div_zero  out  1  divisor was zero (only with DIV_ZERO_DETECT_EN, else tied 0)

## Operation
- States: IDLE, CALC, FIX. Reset → IDLE; busy=0, done=0, q=0, r=0, div_zero=0.
- IDLE with start=1 and abort=0: latch |dividend| and |divisor| (negated only if signed_div=1 and MSB=1); latch q_neg = signed_div & (dvd[MSB]^dvs[MSB]) and r_neg = signed_div & dvd[MSB]; clear partial remainder and counter; go to CALC.
- CALC: one non-restoring step per cycle on a (WIDTH+1)-bit add/sub of {rem, qreg[MSB]} ± {0, divisor}. Sign of result selects the next operation, and its complement is shifted into qreg. After WIDTH steps → FIX.
- FIX: correct the remainder (add divisor back if negative); apply q_neg/r_neg by two's complement; register q, r; pulse done; → IDLE.
- Sign convention: quotient truncates toward zero; remainder takes the dividend's sign.
- Signed MIN / −1: q = MIN (wraps), r = 0. No trap.
- abort in CALC/FIX: → IDLE next edge, no done, q/r keep previous values. abort in IDLE: start ignored.
- start while busy: ignored, no queueing.
- Async reset mid-operation: immediate return to reset values; the operation is lost.

## Timing
- Start sampled at edge E0. CALC occupies E1..E(WIDTH). FIX at E(WIDTH+1). done is high for the cycle after E(WIDTH+1).
- Latency start→done: WIDTH+1 edges (33 for WIDTH=32).
- busy rises after E0 and falls together with the rise of done.
- Back-to-back: start is accepted in the cycle done is high.
- div_zero is updated at the same edge as q/r.

## Configuration
- DIV_ZERO_DETECT_EN defined: divisor==0 at start goes IDLE→FIX directly, skipping CALC. FIX sets q = all ones, r = dividend (unmodified), div_zero = 1, with done after E1. Otherwise div_zero = 0.
- Not defined: no detection. Zero divisor runs the full WIDTH+1 cycles. Results are ISA-undefined and not checked. div_zero is constant 0.

## Structure
- Package div_pkg: state enum (IDLE, CALC, FIX) and DIV_WIDTH_DEFAULT = 32.
- One sub-module, div_cond_neg (WIDTH param, combinational conditional two's complement). It is instantiated for operand absolute values and for result sign application.

## Test plan
- WIDTH=32, unsigned 100/7 → q=14, r=2; done exactly 33 edges after start, busy high for 33 cycles.
- Signed 0xFFFFFFF9/2 (−7/2) → q=0xFFFFFFFD, r=0xFFFFFFFF. Unsigned 0x80000000/2 with signed_div=0 → q=0x40000000, r=0.
- Signed 0x80000000/0xFFFFFFFF → q=0x80000000, r=0. Follow immediately with a start in the done cycle for 9/3 → q=3, r=0 after 33 more edges.
- Abort 10 cycles into 1000/3 → no done, busy low next edge, q/r unchanged. rst_n low mid-CALC → all outputs 0 asynchronously.
- DIV_ZERO_DETECT_EN: 5/0 → div_zero=1, q=0xFFFFFFFF, r=5, done after E1. Next op 6/3 → div_zero=0, q=2.
- WIDTH=8 instance: signed 0x81/0x03 (−127/3) → q=0xD6, r=0xFF; done 9 edges after start.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int unsigned DIV_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/div_cond_neg.sv
// Conditional two's complement: y = neg ? -a : a.
module div_cond_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  // Pass-through or negate.
  always_comb begin
    y = neg ? (~a + WIDTH'(1)) : a;
  end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative radix-2 non-restoring divider, signed or unsigned, WIDTH+1 edge latency.
// Optional feature macro: DIV_ZERO_DETECT_EN (zero divisor short-cuts to FIX,
// q = all ones, r = dividend, div_zero = 1).
module div_iter_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_div,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
  logic             dz_q, dz_d;
  logic             divz_q, divz_d;
`endif

  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   step_in, step_res;
  logic [WIDTH-1:0] rem_fix, q_res, r_res;

  div_cond_neg #(.WIDTH(WIDTH)) u_neg_dvd (
    .a(dividend), .neg(signed_div & dividend[WIDTH-1]), .y(dvd_abs));
  div_cond_neg #(.WIDTH(WIDTH)) u_neg_dvs (
    .a(divisor), .neg(signed_div & divisor[WIDTH-1]), .y(dvs_abs));
  div_cond_neg #(.WIDTH(WIDTH)) u_neg_q (
    .a(qreg_q), .neg(qneg_q), .y(q_res));
  div_cond_neg #(.WIDTH(WIDTH)) u_neg_r (
    .a(rem_fix), .neg(rneg_q), .y(r_res));

  // One non-restoring step; the shifted-out top bit is redundant because the
  // result always lies in [-divisor, divisor) and so fits WIDTH+1 bits.
  always_comb begin
    step_in  = {rem_q[WIDTH-1:0], qreg_q[WIDTH-1]};
    step_res = rem_q[WIDTH] ? (step_in + {1'b0, dvs_q})
                            : (step_in - {1'b0, dvs_q});
    rem_fix  = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + dvs_q) : rem_q[WIDTH-1:0];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    qreg_d  = qreg_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    dz_d    = dz_q;
    divz_d  = divz_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          qreg_d  = dvd_abs;
          dvs_d   = dvs_abs;
          qneg_d  = signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d  = signed_div & dividend[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef DIV_ZERO_DETECT_EN
          dz_d = (divisor == '0);
          if (divisor == '0) begin
            // Keep the raw dividend so FIX can return it unmodified.
            qreg_d  = dividend;
            state_d = FIX;
          end
`endif
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          rem_d  = step_res;
          qreg_d = {qreg_q[WIDTH-2:0], ~step_res[WIDTH]};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!abort) begin
          q_d    = q_res;
          r_d    = r_res;
          done_d = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          divz_d = dz_q;
          if (dz_q) begin
            q_d = '1;
            r_d = qreg_q;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      qreg_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q    <= 1'b0;
      divz_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      qreg_q  <= qreg_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
`ifdef DIV_ZERO_DETECT_EN
      dz_q    <= dz_d;
      divz_q  <= divz_d;
`endif
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div_zero = divz_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit (WIDTH=32 and WIDTH=8 instances).
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, signed_div, abort;
  logic [31:0] dividend, divisor, q, r;
  logic        busy, done, div_zero;
  logic        start8;
  logic [7:0]  dvd8, dvs8, q8, r8;
  logic        busy8, done8, dz8;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int          lat, bcnt;
  logic        seen;

  always #5 clk = ~clk;

  div_iter_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_div(signed_div),
    .abort(abort), .dividend(dividend), .divisor(divisor), .busy(busy),
    .done(done), .q(q), .r(r), .div_zero(div_zero));

  div_iter_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_div(signed_div),
    .abort(abort), .dividend(dvd8), .divisor(dvs8), .busy(busy8),
    .done(done8), .q(q8), .r(r8), .div_zero(dz8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; reports edge latency
  // after the start edge and the number of sampled busy cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat_o, output int bcnt_o);
    @(negedge clk);
    dividend = a; divisor = b; signed_div = s; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    lat_o  = 0;
    bcnt_o = busy ? 1 : 0;
    while (!done && lat_o < 100) begin
      @(posedge clk); #1;
      lat_o++;
      if (!done && busy) bcnt_o++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; signed_div = 1'b0; abort = 1'b0;
    dividend = '0; divisor = '0; start8 = 1'b0; dvd8 = '0; dvs8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_divz", div_zero, 0);
    @(negedge clk) rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, lat, bcnt);
    check("u100_7_lat", lat, 33);
    check("u100_7_busy", bcnt, 33);
    check("u100_7_q", q, 32'd14);
    check("u100_7_r", r, 32'd2);

    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat, bcnt);
    check("sm7_2_q", q, 32'hFFFF_FFFD);
    check("sm7_2_r", r, 32'hFFFF_FFFF);

    run_op(32'h8000_0000, 32'd2, 1'b0, lat, bcnt);
    check("u80_2_q", q, 32'h4000_0000);
    check("u80_2_r", r, 32'd0);

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bcnt);
    check("min_m1_q", q, 32'h8000_0000);
    check("min_m1_r", r, 32'd0);
    // Next start lands in the done cycle.
    run_op(32'd9, 32'd3, 1'b0, lat, bcnt);
    check("b2b_lat", lat, 33);
    check("b2b_q", q, 32'd3);
    check("b2b_r", r, 32'd0);

    // Abort mid-CALC.
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("abort_nodone", seen, 0);
    check("abort_q_hold", q, 32'd3);
    check("abort_r_hold", r, 32'd0);

    // Abort in IDLE blocks start.
    @(negedge clk);
    abort = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check("idle_abort_busy", busy, 0);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", q, 0);
    check("arst_r", r, 0);
    @(negedge clk) rst_n = 1'b1;

`ifdef DIV_ZERO_DETECT_EN
    run_op(32'd5, 32'd0, 1'b0, lat, bcnt);
    check("dz_lat", lat, 1);
    check("dz_flag", div_zero, 1);
    check("dz_q", q, 32'hFFFF_FFFF);
    check("dz_r", r, 32'd5);
`else
    run_op(32'd5, 32'd0, 1'b0, lat, bcnt);
    check("dz_lat_full", lat, 33);
    check("dz_flag_off", div_zero, 0);
`endif
    run_op(32'd6, 32'd3, 1'b0, lat, bcnt);
    check("after_dz_flag", div_zero, 0);
    check("after_dz_q", q, 32'd2);

    // WIDTH=8 instance.
    @(negedge clk);
    dvd8 = 8'h81; dvs8 = 8'h03; signed_div = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8_lat", lat, 9);
    check("w8_q", q8, 32'h0000_00D6);
    check("w8_r", r8, 32'h0000_00FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
